// File: rtl/mil_pkg.sv
// Shared constants for the 1553 RT message assembler: FSM states, error codes, command-word layout.
package mil_pkg;

    localparam int unsigned DAT_W  = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned SA_W   = 5;
    localparam int unsigned WC_W   = 5;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ERR_W  = 3;

    localparam int unsigned ADDR_LSB = 11;
    localparam int unsigned TR_BIT   = 10;
    localparam int unsigned SA_LSB   = 5;
    localparam int unsigned WC_LSB   = 0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    localparam logic [ERR_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [ERR_W-1:0] ERR_PAR      = 3'd1;
    localparam logic [ERR_W-1:0] ERR_SYNC     = 3'd2;
    localparam logic [ERR_W-1:0] ERR_TMO      = 3'd3;
    localparam logic [ERR_W-1:0] ERR_BCAST_TX = 3'd4;

    localparam logic [SA_W-1:0]   SA_MODE0   = 5'd0;
    localparam logic [SA_W-1:0]   SA_MODE31  = 5'd31;
    localparam logic [ADDR_W-1:0] BCAST_ADDR = 5'd31;

    // Command word as it arrives on rx_dat, MSB first.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              tr;
        logic [SA_W-1:0]   sa;
        logic [WC_W-1:0]   wc;
    } cmd_word_t;

    // Word-count field 0 encodes 32 words.
    function automatic logic [CNT_W-1:0] wc_words(input logic [WC_W-1:0] wc);
        return (wc == '0) ? CNT_W'(32) : CNT_W'(wc);
    endfunction

endpackage

// File: rtl/mil_gap_timer.sv
// Inter-word gap timer: counts clk while run, one-clk tmo pulse on reaching TMO_CLK, saturates until clr.
module mil_gap_timer #(
    parameter int unsigned TMO_CLK = 1500,
    parameter int unsigned TMO_W   = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tmo
);

    // cnt_q holds (gap - 1), so the pulse is registered and lands in the cycle the gap equals TMO_CLK.
    localparam logic [TMO_W-1:0] CNT_MAX = TMO_W'(TMO_CLK - 1);
    localparam logic [TMO_W-1:0] CNT_PRE = TMO_W'(TMO_CLK - 2);

    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TMO_W'(1);
            tmo_d = (cnt_q == CNT_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;

endmodule

// File: rtl/mil_rt_msg_rx.sv
// 1553 RT message assembler: decodes commands, writes receive data words, flags completion and errors.
// Optional MIL_RT_BCAST_EN: accept broadcast address 31 and expose the bcast port.
module mil_rt_msg_rx
    import mil_pkg::*;
#(
    parameter int unsigned TMO_CLK = 1500,
    parameter int unsigned TMO_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rx_stb,
    input  logic [DAT_W-1:0]  rx_dat,
    input  logic              rx_cw,
    input  logic              rx_par_ok,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DAT_W-1:0]  wr_dat,
    output logic              cmd_tr,
    output logic [SA_W-1:0]   cmd_sa,
    output logic [CNT_W-1:0]  cmd_wc,
    output logic              tx_req,
    output logic              mode_stb,
    output logic              msg_done,
    output logic              msg_err,
    output logic [ERR_W-1:0]  err_code,
    output logic              busy
`ifdef MIL_RT_BCAST_EN
    ,
    output logic              bcast
`endif
);

`ifdef MIL_RT_BCAST_EN
    localparam bit BCAST_EN = 1'b1;
`else
    localparam bit BCAST_EN = 1'b0;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [DAT_W-1:0] wr_dat_q, wr_dat_d;
    logic             cmd_tr_q, cmd_tr_d;
    logic [SA_W-1:0]  cmd_sa_q, cmd_sa_d;
    logic [CNT_W-1:0] cmd_wc_q, cmd_wc_d;
    logic             tx_req_q, tx_req_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_code_q, err_code_d;
    logic             busy_q, busy_d;
    logic             bcast_q, bcast_d;

    cmd_word_t cw;
    logic      is_bcast;
    logic      addr_ok;
    logic      eval;
    logic      tmo;

    assign cw       = cmd_word_t'(rx_dat);
    assign is_bcast = BCAST_EN && (cw.addr == BCAST_ADDR);
    assign addr_ok  = (cw.addr == rt_addr) || is_bcast;

    mil_gap_timer #(
        .TMO_CLK (TMO_CLK),
        .TMO_W   (TMO_W)
    ) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == S_DATA),
        .clr   (rx_stb),
        .tmo   (tmo)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_dat_d   = wr_dat_q;
        cmd_tr_d   = cmd_tr_q;
        cmd_sa_d   = cmd_sa_q;
        cmd_wc_d   = cmd_wc_q;
        tx_req_d   = 1'b0;
        mode_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        bcast_d    = bcast_q;
        eval       = 1'b0;

        case (state_q)
            S_IDLE: eval = rx_stb && rx_cw;
            S_DATA: begin
                if (rx_stb) begin
                    if (rx_cw) begin
                        // New command mid-message aborts, then is decoded as a fresh command.
                        err_d      = 1'b1;
                        err_code_d = ERR_SYNC;
                        state_d    = S_IDLE;
                        eval       = 1'b1;
                    end else if (!rx_par_ok) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PAR;
                        state_d    = S_IDLE;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[4:0];
                        wr_dat_d  = rx_dat;
                        idx_d     = idx_q + CNT_W'(1);
                        if (idx_d == cmd_wc_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else if (tmo) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (eval && rx_par_ok && addr_ok) begin
            cmd_tr_d = cw.tr;
            cmd_sa_d = cw.sa;
            cmd_wc_d = wc_words(cw.wc);
            bcast_d  = is_bcast;
            if ((cw.sa == SA_MODE0) || (cw.sa == SA_MODE31)) begin
                mode_d = 1'b1;
            end else if (cw.tr) begin
                if (is_bcast) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BCAST_TX;
                end else begin
                    tx_req_d = 1'b1;
                end
            end else begin
                state_d = S_DATA;
                idx_d   = '0;
            end
        end

        busy_d = (state_d == S_DATA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_dat_q   <= '0;
            cmd_tr_q   <= 1'b0;
            cmd_sa_q   <= '0;
            cmd_wc_q   <= '0;
            tx_req_q   <= 1'b0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b0;
            bcast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_dat_q   <= wr_dat_d;
            cmd_tr_q   <= cmd_tr_d;
            cmd_sa_q   <= cmd_sa_d;
            cmd_wc_q   <= cmd_wc_d;
            tx_req_q   <= tx_req_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            bcast_q    <= bcast_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_dat   = wr_dat_q;
    assign cmd_tr   = cmd_tr_q;
    assign cmd_sa   = cmd_sa_q;
    assign cmd_wc   = cmd_wc_q;
    assign tx_req   = tx_req_q;
    assign mode_stb = mode_q;
    assign msg_done = done_q;
    assign msg_err  = err_q;
    assign err_code = err_code_q;
    assign busy     = busy_q;
`ifdef MIL_RT_BCAST_EN
    assign bcast    = bcast_q;
`else
    logic unused_bcast;
    assign unused_bcast = bcast_q;
`endif

endmodule

// File: tb/tb_mil_rt_msg_rx.sv
// Bench for mil_rt_msg_rx: per-cycle comparison against a message-level model plus directed literal checks.
module tb_mil_rt_msg_rx;

    localparam int TMO = 1500;
`ifdef MIL_RT_BCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rt_addr = 5'd5;
    logic        rx_stb = 1'b0;
    logic [15:0] rx_dat = 16'h0;
    logic        rx_cw = 1'b0;
    logic        rx_par_ok = 1'b0;
    logic        wr_en, cmd_tr, tx_req, mode_stb, msg_done, msg_err, busy;
    logic [4:0]  wr_addr, cmd_sa;
    logic [15:0] wr_dat;
    logic [5:0]  cmd_wc;
    logic [2:0]  err_code;
`ifdef MIL_RT_BCAST_EN
    logic        bcast;
`endif

    always #5 clk = ~clk;

    mil_rt_msg_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rt_addr   (rt_addr),
        .rx_stb    (rx_stb),
        .rx_dat    (rx_dat),
        .rx_cw     (rx_cw),
        .rx_par_ok (rx_par_ok),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_dat    (wr_dat),
        .cmd_tr    (cmd_tr),
        .cmd_sa    (cmd_sa),
        .cmd_wc    (cmd_wc),
        .tx_req    (tx_req),
        .mode_stb  (mode_stb),
        .msg_done  (msg_done),
        .msg_err   (msg_err),
        .err_code  (err_code),
        .busy      (busy)
`ifdef MIL_RT_BCAST_EN
        ,
        .bcast     (bcast)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Message-level model: expected outputs for the cycle after each edge.
    bit e_wr_en, e_tr, e_tx, e_mode, e_done, e_err, e_busy, e_bc;
    int e_wr_addr, e_wr_dat, e_sa, e_wc, e_code;
    bit in_msg, cmd_seen, m_tr, m_bc;
    int idx, gap, m_a, m_sa, m_wc;

    always @(posedge clk) begin
        e_wr_en = 0; e_tx = 0; e_mode = 0; e_done = 0; e_err = 0;
        if (!rst_n) begin
            e_wr_addr = 0; e_wr_dat = 0; e_tr = 0; e_sa = 0; e_wc = 0; e_code = 0; e_bc = 0;
            in_msg = 0; idx = 0; gap = 0;
        end else begin
            cmd_seen = 0;
            if (in_msg) begin
                if (rx_stb) begin
                    gap = 0;
                    if (rx_cw) begin
                        e_err = 1; e_code = 2; in_msg = 0; cmd_seen = 1;
                    end else if (!rx_par_ok) begin
                        e_err = 1; e_code = 1; in_msg = 0;
                    end else begin
                        e_wr_en = 1; e_wr_addr = idx; e_wr_dat = int'(rx_dat);
                        idx++;
                        if (idx == e_wc) begin e_done = 1; in_msg = 0; end
                    end
                end else begin
                    gap++;
                    if (gap >= TMO) begin e_err = 1; e_code = 3; in_msg = 0; end
                end
            end else begin
                cmd_seen = rx_stb && rx_cw;
            end
            if (cmd_seen && rx_par_ok) begin
                m_a  = int'(rx_dat) / 2048;
                m_tr = rx_dat[10];
                m_sa = (int'(rx_dat) / 32) % 32;
                m_wc = int'(rx_dat) % 32;
                m_bc = BC && (m_a == 31);
                if (m_a == int'(rt_addr) || m_bc) begin
                    e_tr = m_tr; e_sa = m_sa; e_wc = (m_wc == 0) ? 32 : m_wc; e_bc = m_bc;
                    if (m_sa == 0 || m_sa == 31) e_mode = 1;
                    else if (m_tr) begin
                        if (m_bc) begin e_err = 1; e_code = 4; end
                        else e_tx = 1;
                    end else begin
                        in_msg = 1; idx = 0; gap = 0;
                    end
                end
            end
        end
        e_busy = in_msg;
    end

    // Event tallies for the literal checks.
    int n_wr = 0, n_done = 0, n_err = 0, n_tx = 0, n_mode = 0;

    always @(negedge clk) begin
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
            chk("wr_dat", 32'(wr_dat), 32'(e_wr_dat));
        end
        chk("cmd_tr", 32'(cmd_tr), 32'(e_tr));
        chk("cmd_sa", 32'(cmd_sa), 32'(e_sa));
        chk("cmd_wc", 32'(cmd_wc), 32'(e_wc));
        chk("tx_req", 32'(tx_req), 32'(e_tx));
        chk("mode_stb", 32'(mode_stb), 32'(e_mode));
        chk("msg_done", 32'(msg_done), 32'(e_done));
        chk("msg_err", 32'(msg_err), 32'(e_err));
        chk("err_code", 32'(err_code), 32'(e_code));
        chk("busy", 32'(busy), 32'(e_busy));
`ifdef MIL_RT_BCAST_EN
        chk("bcast", 32'(bcast), 32'(e_bc));
`endif
        if (wr_en === 1'b1)    n_wr++;
        if (msg_done === 1'b1) n_done++;
        if (msg_err === 1'b1)  n_err++;
        if (tx_req === 1'b1)   n_tx++;
        if (mode_stb === 1'b1) n_mode++;
    end

    task automatic send(input logic [15:0] d, input logic cw, input logic p);
        rx_dat = d; rx_cw = cw; rx_par_ok = p; rx_stb = 1'b1;
        @(posedge clk); #1;
        rx_stb = 1'b0; rx_cw = 1'b0; rx_par_ok = 1'b0; rx_dat = 16'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int s_wr, s_done, s_err, s_tx, s_mode;
    task automatic snap();
        s_wr = n_wr; s_done = n_done; s_err = n_err; s_tx = n_tx; s_mode = n_mode;
    endtask

    initial begin
        idle(3);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_cmd_wc", 32'(cmd_wc), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: five-word receive message
        snap();
        send(16'h2865, 1, 1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) send(16'(i * 16'h1111), 0, 1);
        chk("t1_done_now", 32'(msg_done), 32'd1);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        idle(3);
        chk("t1_writes", 32'(n_wr - s_wr), 32'd5);
        chk("t1_done", 32'(n_done - s_done), 32'd1);
        chk("t1_cmd_sa", 32'(cmd_sa), 32'd3);
        chk("t1_cmd_wc", 32'(cmd_wc), 32'd5);

        // 2: transmit command, wc 0 means 32
        snap();
        send(16'h2C40, 1, 1);
        idle(3);
        chk("t2_tx_req", 32'(n_tx - s_tx), 32'd1);
        chk("t2_cmd_wc", 32'(cmd_wc), 32'd32);
        chk("t2_cmd_tr", 32'(cmd_tr), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);

        // 3: timeout after two of four words
        snap();
        send(16'h2864, 1, 1);
        send(16'hA001, 0, 1);
        send(16'hA002, 0, 1);
        idle(TMO + 10);
        chk("t3_err", 32'(n_err - s_err), 32'd1);
        chk("t3_code", 32'(err_code), 32'd3);
        chk("t3_done", 32'(n_done - s_done), 32'd0);
        chk("t3_writes", 32'(n_wr - s_wr), 32'd2);

        // gap boundary: a word in the same clk as the timeout wins
        snap();
        send(16'h2862, 1, 1);
        send(16'hB001, 0, 1);
        idle(TMO - 1);
        send(16'hB002, 0, 1);
        idle(3);
        chk("tb_err", 32'(n_err - s_err), 32'd0);
        chk("tb_done", 32'(n_done - s_done), 32'd1);

        // 4: new command mid-message supersedes
        snap();
        send(16'h2863, 1, 1);
        send(16'hC001, 0, 1);
        send(16'h2825, 1, 1);
        chk("t4_code", 32'(err_code), 32'd2);
        chk("t4_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) send(16'(16'hC100 + 16'(i)), 0, 1);
        idle(3);
        chk("t4_err", 32'(n_err - s_err), 32'd1);
        chk("t4_done", 32'(n_done - s_done), 32'd1);
        chk("t4_writes", 32'(n_wr - s_wr), 32'd6);
        chk("t4_cmd_sa", 32'(cmd_sa), 32'd1);

        // 5: parity error, then stray data word in idle
        snap();
        send(16'h2863, 1, 1);
        send(16'hD001, 0, 1);
        send(16'hD002, 0, 0);
        send(16'hD003, 0, 1);
        idle(3);
        chk("t5_code", 32'(err_code), 32'd1);
        chk("t5_writes", 32'(n_wr - s_wr), 32'd1);
        chk("t5_err", 32'(n_err - s_err), 32'd1);

        // mode commands on SA 0 and SA 31
        snap();
        send(16'h2800, 1, 1);
        send(16'h2BE1, 1, 1);
        idle(2);
        chk("mode_cnt", 32'(n_mode - s_mode), 32'd2);
        chk("mode_busy", 32'(busy), 32'd0);

        // ignored words: other address, bad parity, data sync
        snap();
        send(16'h3065, 1, 1);
        send(16'h2865, 1, 0);
        send(16'h2865, 0, 1);
        idle(3);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_cmd_sa", 32'(cmd_sa), 32'd31);
        chk("ign_writes", 32'(n_wr - s_wr), 32'd0);

        // reset mid-message: silent abort
        snap();
        send(16'h2865, 1, 1);
        send(16'hE001, 0, 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("rst_mid_wc", 32'(cmd_wc), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        idle(3);
        chk("rst_mid_err", 32'(n_err - s_err), 32'd0);

        // 6: address 31 with rt_addr 5
        snap();
        send(16'hF865, 1, 1);
        for (int i = 0; i < 5; i++) send(16'(16'hF000 + 16'(i)), 0, 1);
        idle(3);
        chk("t6_done", 32'(n_done - s_done), BC ? 32'd1 : 32'd0);
        chk("t6_writes", 32'(n_wr - s_wr), BC ? 32'd5 : 32'd0);
`ifdef MIL_RT_BCAST_EN
        chk("t6_bcast", 32'(bcast), 32'd1);
        snap();
        send(16'hFC45, 1, 1);
        idle(2);
        chk("t6_btx_code", 32'(err_code), 32'd4);
        chk("t6_btx_tx", 32'(n_tx - s_tx), 32'd0);
`endif

        // own address 31 always accepted
        rt_addr = 5'd31;
        snap();
        send(16'hF862, 1, 1);
        send(16'h1234, 0, 1);
        send(16'h5678, 0, 1);
        idle(3);
        chk("a31_done", 32'(n_done - s_done), 32'd1);
        rt_addr = 5'd5;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
